srl_log: RTL



---
 rtl/srl_log_if.sv | 39 +++
 rtl/srl_log.sv | 97 +++++++++
 2 files changed

// File: rtl/srl_log_if.sv
`default_nettype none
// ============================================================================
//  Module   : srl_log_if
//  Purpose  : Handshake/data bundle for the constant-time shift-right unit.
//             The requester (master) drives start/arith/in/shift; the shifter
//             (slave) returns out/busy/done.
//  Ports    : start  - request, sampled only while the shifter is idle
//             arith  - 1 = sign fill, 0 = zero fill
//             in     - SIZE-bit operand
//             shift  - LOGSIZE-bit shift amount
//             out    - SIZE-bit result register
//             busy   - shift in progress
//             done   - one-cycle pulse, out holds the final result
//  Revision : 1.0 - initial release
// ============================================================================
interface srl_log_if #(
  parameter int LOGSIZE = 8
) ();
  localparam int SIZE = 1 << LOGSIZE;

  logic               start;
  logic               arith;
  logic [SIZE-1:0]    in;
  logic [LOGSIZE-1:0] shift;
  logic [SIZE-1:0]    out;
  logic               busy;
  logic               done;

  modport master (
    output start, arith, in, shift,
    input  out, busy, done
  );

  modport slave (
    input  start, arith, in, shift,
    output out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/srl_log.sv
`default_nettype none
// ============================================================================
//  Module   : srl_log
//  Purpose  : Constant-time logical/arithmetic shift-right. Operand, amount
//             and mode are latched on start; then exactly LOGSIZE stages run,
//             one binary-weighted stage per cycle, whatever the shift amount.
//             done pulses for one cycle when out holds the result.
//  Ports    : clock - single clock, rising edge
//             reset - synchronous, active-high
//             bus   - srl_log_if slave modport (start/arith/in/shift in,
//                     out/busy/done out)
//  Revision : 1.0 - initial release
// ============================================================================
module srl_log #(
  parameter int LOGSIZE = 8
) (
  input  logic      clock,
  input  logic      reset,
  srl_log_if.slave  bus
);
  localparam int SIZE = 1 << LOGSIZE;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [SIZE-1:0]    value_q;
  logic [SIZE-1:0]    value_d;
  logic [LOGSIZE-1:0] s_q;
  logic [LOGSIZE-1:0] step_q;
  logic               fill_q;
  logic               busy_q;
  logic               done_q;

  // Candidate result of every stage, computed unconditionally each cycle so
  // the datapath activity does not depend on the shift amount.
  logic [SIZE-1:0] stage_val [LOGSIZE];

  for (genvar gi = 0; gi < LOGSIZE; gi++) begin : g_stage
    assign stage_val[gi] = {{(2**gi){fill_q}}, value_q[SIZE-1:(2**gi)]};
  end

  // step_q is one-hot in RUN and zero in IDLE, so at most one stage is
  // selected; an unselected or zero-bit stage keeps the value.
  always_comb begin
    value_d = value_q;
    for (int i = 0; i < LOGSIZE; i++) begin
      if (step_q[i] && s_q[i]) begin
        value_d = stage_val[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      value_q <= '0;
      s_q     <= '0;
      fill_q  <= 1'b0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            value_q <= bus.in;
            s_q     <= bus.shift;
            fill_q  <= bus.arith & bus.in[SIZE-1];
            step_q  <= LOGSIZE'(1);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          value_q <= value_d;
          step_q  <= step_q << 1;
          if (step_q[LOGSIZE-1]) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out  = value_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire
